dmem_responder: RTL and testbench

//   Data-memory responder for the MEM stage of the pipelined MIPS core. Accepts the

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory for the MEM stage with configurable load/store latency.
// Holds the pipeline via stallM while an access is in flight and flags illegal requests.
module dmem_responder #(
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        faultM
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] RD_L = 4'(RD_LAT);
  localparam logic [3:0] WR_L = 4'(WR_LAT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    count_reg, count_next;
  logic [IW-1:0] idx_reg;
  logic [31:0]   data_reg;
  logic          is_write_reg;
  logic [31:0]   readdata_reg;
  logic          fault_reg, fault_next;
  logic [31:0]   ram [DEPTH];

  logic          req, bad, latch, ram_we, rd_load, rd_bypass, stall;
  logic [IW-1:0] in_idx, ram_widx, rd_idx;
  logic [31:0]   ram_wdata;
  logic [3:0]    req_lat;

  assign req     = memreadM | memwriteM;
  assign in_idx  = aluoutM[IW+1:2];
  assign bad     = (aluoutM[1:0] != 2'b00) ||
                   ({2'b00, aluoutM[31:2]} >= 32'(DEPTH)) ||
                   (memreadM && memwriteM);
  assign req_lat = memwriteM ? WR_L : RD_L;
  // In IDLE the request is still on the inputs; afterwards only the latched copy counts.
  assign rd_idx  = (state_reg == IDLE) ? in_idx : idx_reg;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    fault_next = 1'b0;
    stall      = 1'b0;
    latch      = 1'b0;
    ram_we     = 1'b0;
    ram_widx   = idx_reg;
    ram_wdata  = data_reg;
    rd_load    = 1'b0;
    rd_bypass  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (bad) begin
            fault_next = 1'b1;
          end else begin
            latch = 1'b1;
            if (req_lat == 4'd0) begin
              if (memwriteM) begin
                ram_we    = 1'b1;
                ram_widx  = in_idx;
                ram_wdata = writedataM;
              end else begin
                rd_load   = 1'b1;
                rd_bypass = 1'b1;
              end
            end else begin
              stall      = 1'b1;
              count_next = req_lat - 4'd1;
              if (req_lat == 4'd1) begin
                state_next = DONE;
                rd_load    = ~memwriteM;
              end else begin
                state_next = BUSY;
              end
            end
          end
        end
      end
      BUSY: begin
        stall      = 1'b1;
        count_next = count_reg - 4'd1;
        // Loads are read on the edge into DONE so the registered data shows in DONE.
        if (count_reg == 4'd1) begin
          state_next = DONE;
          rd_load    = ~is_write_reg;
        end
      end
      DONE: begin
        state_next = IDLE;
        ram_we     = is_write_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  assign readdataM = rd_bypass ? ram[in_idx] : readdata_reg;
  assign stallM    = stall & ~reset;
  assign faultM    = fault_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= 4'd0;
      idx_reg      <= '0;
      data_reg     <= 32'd0;
      is_write_reg <= 1'b0;
      readdata_reg <= 32'd0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      fault_reg <= fault_next;
      if (latch) begin
        idx_reg      <= in_idx;
        data_reg     <= writedataM;
        is_write_reg <= memwriteM;
      end
      if (rd_load) readdata_reg <= ram[rd_idx];
    end
  end

  // A reset on the committing edge drops the pending store.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) ram[ram_widx] <= ram_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with RD_LAT=2/WR_LAT=1, one with zero latency.
// Stimulus pushes cycle-stamped expectations; a negedge monitor pops and compares them.
module tb_dmem_responder;

  localparam int K_STALL = 0;
  localparam int K_RDATA = 1;
  localparam int K_FAULT = 2;

  typedef struct {
    int          cyc;
    int          inst;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_a, wr_a, stall_a, fault_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        rd_z, wr_z, stall_z, fault_z;
  logic [31:0] addr_z, wdata_z, rdata_z;

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          checking = 1'b0;
  logic [31:0] held_a = 32'd0;
  logic [31:0] held_z = 32'd0;
  exp_t        sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(64), .RD_LAT(2), .WR_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .memreadM(rd_a), .memwriteM(wr_a), .aluoutM(addr_a),
    .writedataM(wdata_a), .readdataM(rdata_a), .stallM(stall_a), .faultM(fault_a)
  );

  dmem_responder #(.DEPTH(64), .RD_LAT(0), .WR_LAT(0)) u_dut_zero (
    .clk(clk), .reset(reset), .memreadM(rd_z), .memwriteM(wr_z), .aluoutM(addr_z),
    .writedataM(wdata_z), .readdataM(rdata_z), .stallM(stall_z), .faultM(fault_z)
  );

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst=%0d cycle=%0d got=%h expected=%h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic push(input int inst, input int kind, input int ofs, input logic [31:0] val);
    exp_t e;
    e.cyc  = cyc + ofs;
    e.inst = inst;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic step(input int inst, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_stall);
    rd_a = 1'b0; wr_a = 1'b0; addr_a = 32'd0; wdata_a = 32'd0;
    rd_z = 1'b0; wr_z = 1'b0; addr_z = 32'd0; wdata_z = 32'd0;
    if (inst == 0) begin
      rd_a = rd; wr_a = wr; addr_a = a; wdata_a = d;
    end else begin
      rd_z = rd; wr_z = wr; addr_z = a; wdata_z = d;
    end
    if (rd || wr)
      $display("[TB] cycle=%0d inst=%0d rd=%0b wr=%0b addr=%h data=%h rst=%0b",
               cyc, inst, rd, wr, a, d, reset);
    push(inst, K_STALL, 0, {31'd0, exp_stall});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push(0, K_RDATA, 0, held_a);
    step(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // Store: stall only in the request cycle; the DONE cycle carries a different request
  // that must be ignored.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] a2, input logic [31:0] d2);
    push(0, K_RDATA, 0, held_a);
    step(0, 1'b0, 1'b1, a, d, 1'b1);
    push(0, K_RDATA, 0, held_a);
    step(0, 1'b0, 1'b1, a2, d2, 1'b0);
  endtask

  // Load: stall in T and T+1 (address changed in T+1), data in T+2 and held after.
  task automatic do_load(input logic [31:0] a, input logic [31:0] a2, input logic [31:0] exp);
    push(0, K_RDATA, 0, held_a);
    step(0, 1'b1, 1'b0, a, 32'd0, 1'b1);
    push(0, K_RDATA, 0, held_a);
    step(0, 1'b1, 1'b0, a2, 32'd0, 1'b1);
    held_a = exp;
    push(0, K_RDATA, 0, held_a);
    step(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    idle();
  endtask

  task automatic do_fault(input logic rd, input logic wr, input logic [31:0] a);
    push(0, K_RDATA, 0, held_a);
    push(0, K_FAULT, 1, 32'd1);
    step(0, rd, wr, a, 32'hFFFF_FFFF, 1'b0);
    idle();
  endtask

  always @(negedge clk) begin
    logic fe_a, fe_z;
    if (checking) begin
      fe_a = 1'b0;
      fe_z = 1'b0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc < cyc) begin
          tests++;
          fails++;
          $display("FAIL stale_entry kind=%0d due=%0d now=%0d", sb[i].kind, sb[i].cyc, cyc);
          sb.delete(i);
        end else if (sb[i].cyc == cyc) begin
          case (sb[i].kind)
            K_STALL: chk("stallM", sb[i].inst, {31'd0, (sb[i].inst == 0) ? stall_a : stall_z},
                         sb[i].val);
            K_RDATA: chk("readdataM", sb[i].inst, (sb[i].inst == 0) ? rdata_a : rdata_z,
                         sb[i].val);
            default: if (sb[i].inst == 0) fe_a = 1'b1; else fe_z = 1'b1;
          endcase
          sb.delete(i);
        end
      end
      chk("faultM", 0, {31'd0, fault_a}, {31'd0, fe_a});
      chk("faultM", 1, {31'd0, fault_z}, {31'd0, fe_z});
    end
  end

  initial begin
    logic [31:0] vals [4];
    vals[0] = 32'h1111_1111; vals[1] = 32'h2222_2222;
    vals[2] = 32'h3333_3333; vals[3] = 32'h4444_4444;
    reset = 1'b1;
    rd_a = 1'b0; wr_a = 1'b0; addr_a = 32'd0; wdata_a = 32'd0;
    rd_z = 1'b0; wr_z = 1'b0; addr_z = 32'd0; wdata_z = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    push(1, K_RDATA, 0, 32'd0);
    idle();
    reset = 1'b0;
    repeat (5) begin
      push(1, K_RDATA, 0, 32'd0);
      idle();
    end

    do_store(32'h10, 32'hDEAD_BEEF, 32'h10, 32'hDEAD_BEEF);
    do_load(32'h10, 32'h10, 32'hDEAD_BEEF);
    idle();

    do_store(32'h0, 32'h600D_D00D, 32'h0, 32'h600D_D00D);
    do_fault(1'b1, 1'b0, 32'h13);
    do_fault(1'b1, 1'b0, 32'h100);
    do_fault(1'b1, 1'b1, 32'h10);
    do_fault(1'b0, 1'b1, 32'h12);
    do_fault(1'b0, 1'b1, 32'h100);
    do_load(32'h10, 32'h0, 32'hDEAD_BEEF);
    do_load(32'h0, 32'h10, 32'h600D_D00D);

    do_store(32'h24, 32'h5555_5555, 32'h24, 32'h5555_5555);
    do_store(32'h20, 32'hA5A5_A5A5, 32'h24, 32'hFFFF_FFFF);
    do_load(32'h20, 32'h24, 32'hA5A5_A5A5);
    do_load(32'h24, 32'h20, 32'h5555_5555);
    do_store(32'hFC, 32'h0F0F_0F0F, 32'h4, 32'h0);
    do_load(32'hFC, 32'h0, 32'h0F0F_0F0F);

    do_store(32'h8, 32'hCAFE_F00D, 32'h8, 32'hCAFE_F00D);
    push(0, K_RDATA, 0, held_a);
    step(0, 1'b0, 1'b1, 32'h8, 32'h0000_1234, 1'b1);
    reset = 1'b1;
    step(0, 1'b0, 1'b1, 32'h8, 32'h0000_1234, 1'b0);
    reset = 1'b0;
    held_a = 32'd0;
    held_z = 32'd0;
    push(1, K_RDATA, 0, 32'd0);
    idle();
    do_load(32'h8, 32'h8, 32'hCAFE_F00D);

    for (int i = 0; i < 4; i++) begin
      push(1, K_RDATA, 0, held_z);
      step(1, 1'b0, 1'b1, 32'h4, vals[i], 1'b0);
      held_z = vals[i];
      push(1, K_RDATA, 0, held_z);
      step(1, 1'b1, 1'b0, 32'h4, 32'd0, 1'b0);
    end
    push(1, K_RDATA, 0, held_z);
    push(1, K_FAULT, 1, 32'd1);
    step(1, 1'b1, 1'b0, 32'h6, 32'd0, 1'b0);
    push(1, K_RDATA, 0, held_z);
    step(1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    idle();
    idle();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
